midi_msg_parser: RTL and testbench
==================================

# midi_msg_parser

Reads raw MIDI bytes from the receiver's output byte FIFO and assembles them into complete channel-voice and real-time messages for the synthesizer core. Owns the FIFO read side (rd_en/empty), tracks running status, drops SysEx/system-common traffic, and presents one message at a time on a valid/ready handshake.

## Interface
- DROP_CNT_W, default 8: width of the saturating dropped-byte counter.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- fifo_dout  in  8  byte from the FIFO; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop strobe, one cycle per byte.
- msg_valid  out  1  message available.
- msg_ready  in  1  consumer accepts the message when high with msg_valid.
- msg_status  out  8  status byte.
- msg_data1  out  7  first data byte, 0 if unused.
- msg_data2  out  7  second data byte, 0 if unused.
- msg_len  out  2  number of data bytes: 0, 1 or 2.
- drop_cnt  out  DROP_CNT_W  count of discarded data bytes; saturates at all-ones.

## Operation
- FSM states:
  - S_REQ: if !fifo_empty, assert fifo_rd_en and go to S_LAT; otherwise stay.
  - S_LAT: classify fifo_dout. Go to S_EMIT if a message completes, otherwise go to S_REQ.
  - S_EMIT: hold msg_valid. On msg_valid&&msg_ready go to S_REQ.
- Byte 0xF8–0xFF (real-time): emit immediately with msg_status=byte, len 0, data 0. Running status, partial data and the discard flag are untouched.
- Byte 0x80–0xEF (channel status): latch as running status and clear the data count. Expected length is 1 for 0xC_/0xD_ and 2 for all others. Clear the discard flag.
- Byte 0xF0–0xF7 (SysEx/system common): invalidate running status and set the discard flag. The byte itself is not counted.
- Data byte 0x00–0x7F:
  - If the discard flag is set or no running status exists: drop the byte and increment drop_cnt (saturating).
  - Otherwise store it into data1, then data2. When the count reaches the expected length, emit and reset the count to 0.
- A status byte arriving mid-message abandons the partial message. Abandoned data bytes are not counted.
- Message fields are registered at entry to S_EMIT and stay stable until acceptance.

## Timing
- Reset values: fifo_rd_en=0, msg_valid=0, msg_status=0, msg_data1=0, msg_data2=0, msg_len=0, drop_cnt=0. FSM=S_REQ, running status invalid, discard flag clear.
- fifo_rd_en is never high in S_LAT or S_EMIT, or while fifo_empty=1.
- Latency: fifo_rd_en for the completing byte at cycle t; msg_valid=1 at cycle t+2.
- Throughput: at most one byte per 2 cycles. One accepted message costs 1 extra cycle, because msg_ready is sampled in S_EMIT and the FSM returns to S_REQ.
- msg_valid deasserts the cycle after acceptance. There is no combinational path from msg_ready to fifo_rd_en.
- Reset asserted mid-operation: all state clears asynchronously. A byte popped but not yet classified is lost.

## Configuration
- MIDI_RUNNING_STATUS_EN defined:
  - Channel status persists after a message is emitted.
  - Further data byte pairs/singles reuse it.
- Undefined:
  - Running status is invalidated after every emitted channel message.
  - Data bytes without a fresh status byte are dropped and counted.
  - Real-time handling is unchanged.

## Structure
- Shared package midi_pkg holds:
  - FSM state enum.
  - Status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CC=4'hB, PROG=4'hC, CH_AT=4'hD, PITCH=4'hE).
  - Real-time threshold 8'hF8.
  - Message struct type (status, data1, data2, len).
- Sub-module midi_status_decode: combinational. Maps a byte to {is_rt, is_chan, is_sys, is_data, expected_len}.

## Test plan
- Note on: feed 0x90 0x3C 0x64 → one message: status 0x90, d1 0x3C, d2 0x64, len 2. msg_valid rises exactly 2 cycles after the last fifo_rd_en.
- Running status: feed 0x90 0x3C 0x64 0x40 0x00.
  - With macro: second message 0x90/0x40/0x00.
  - Without macro: only one message; drop_cnt=2.
- Real-time interleave: feed 0x90 0x3C 0xF8 0x64 → first message 0xF8 len 0, then 0x90/0x3C/0x64.
- Program change: feed 0xC5 0x07 → status 0xC5, d1 0x07, d2 0, len 1.
- Backpressure: complete a message while msg_ready=0 for 10 cycles with a non-empty FIFO → msg_valid and fields stable, fifo_rd_en=0 throughout. Accepted on the cycle msg_ready rises.
- SysEx/saturation: feed 0xF0 0x01 0x02 0xF7 0x3C → no message, drop_cnt=3. Then 300 orphan data bytes → drop_cnt=8'hFF. Async reset mid-message → all outputs 0 immediately.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared types and constants for the MIDI message parser.
// Holds the parser FSM state enum, status nibble constants, the real-time
// threshold and the packed message record handed to the synthesizer core.
package midi_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_LAT  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [3:0] SYS_NIB  = 4'hF;

  localparam logic [7:0] RT_THRESH = 8'hF8;

  typedef struct packed {
    logic [7:0] status;
    logic [6:0] data1;
    logic [6:0] data2;
    logic [1:0] len;
  } midi_msg_t;

  // Program change and channel aftertouch carry one data byte, the rest two.
  function automatic logic [1:0] chan_len(input logic [3:0] nib);
    return ((nib == PROG) || (nib == CH_AT)) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_status_decode.sv
// midi_status_decode: purely combinational byte classifier.
// Splits a raw MIDI byte into real-time, channel status, system (SysEx /
// system common) or data, and reports the data length of channel messages.
import midi_pkg::*;

module midi_status_decode (
  input  logic [7:0] din,
  output logic       is_rt,
  output logic       is_chan,
  output logic       is_sys,
  output logic       is_data,
  output logic [1:0] expected_len
);

  // Classify the byte; the four categories are mutually exclusive and cover every value.
  always_comb begin
    is_rt        = (din >= RT_THRESH);
    is_data      = ~din[7];
    is_sys       = (din[7:4] == SYS_NIB) && (din < RT_THRESH);
    is_chan      = din[7] && (din[7:4] != SYS_NIB);
    expected_len = chan_len(din[7:4]);
  end

endmodule

// File: rtl/midi_msg_parser.sv
// midi_msg_parser: pops bytes from the receiver FIFO, assembles channel-voice
// and real-time messages and presents them one at a time on valid/ready.
// Optional feature macro: MIDI_RUNNING_STATUS_EN keeps the channel status
// alive after a message so further data bytes reuse it; without it every
// channel message needs a fresh status byte.
import midi_pkg::*;

module midi_msg_parser #(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  msg_valid,
  input  logic                  msg_ready,
  output logic [7:0]            msg_status,
  output logic [6:0]            msg_data1,
  output logic [6:0]            msg_data2,
  output logic [1:0]            msg_len,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  state_t                state;
  state_t                next_state;

  logic                  is_rt;
  logic                  is_chan;
  logic                  is_sys;
  logic                  is_data;
  logic [1:0]            dec_len;

  logic [7:0]            run_status;
  logic                  run_valid;
  logic                  discard;
  logic [1:0]            data_cnt;
  logic [1:0]            exp_len;
  logic [6:0]            data1_hold;
  midi_msg_t             msg_q;
  logic [DROP_CNT_W-1:0] drop_q;

  logic                  data_ok;
  logic                  msg_done;

  midi_status_decode u_decode (
    .din          (fifo_dout),
    .is_rt        (is_rt),
    .is_chan      (is_chan),
    .is_sys       (is_sys),
    .is_data      (is_data),
    .expected_len (dec_len)
  );

  // A data byte is usable only under a live running status outside a SysEx block;
  // a message completes on any real-time byte or on the last data byte expected.
  always_comb begin
    data_ok  = is_data && run_valid && !discard;
    msg_done = is_rt || (data_ok && ((data_cnt + 2'd1) == exp_len));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_REQ;
    else        state <= next_state;
  end

  // Next-state logic: request, classify the popped byte, then hold until accepted.
  always_comb begin
    next_state = state;
    case (state)
      S_REQ:   if (!fifo_empty) next_state = S_LAT;
      S_LAT:   next_state = msg_done ? S_EMIT : S_REQ;
      S_EMIT:  if (msg_ready) next_state = S_REQ;
      default: next_state = S_REQ;
    endcase
  end

  // Outputs: the pop strobe depends only on state and the empty flag (never on
  // msg_ready) and is held low while reset is asserted.
  always_comb begin
    fifo_rd_en = reset && (state == S_REQ) && !fifo_empty;
    msg_valid  = (state == S_EMIT);
    msg_status = msg_q.status;
    msg_data1  = msg_q.data1;
    msg_data2  = msg_q.data2;
    msg_len    = msg_q.len;
    drop_cnt   = drop_q;
  end

  // Byte classification and message assembly, done in the cycle after the pop.
  // The message record is only written on the way into S_EMIT, so it stays
  // stable while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_status <= '0;
      run_valid  <= 1'b0;
      discard    <= 1'b0;
      data_cnt   <= '0;
      exp_len    <= '0;
      data1_hold <= '0;
      msg_q      <= '0;
      drop_q     <= '0;
    end else if (state == S_LAT) begin
      if (is_rt) begin
        msg_q <= '{fifo_dout, 7'd0, 7'd0, 2'd0};
      end else if (is_chan) begin
        run_status <= fifo_dout;
        run_valid  <= 1'b1;
        exp_len    <= dec_len;
        data_cnt   <= '0;
        discard    <= 1'b0;
      end else if (is_sys) begin
        run_valid <= 1'b0;
        discard   <= 1'b1;
        data_cnt  <= '0;
      end else if (data_ok) begin
        if (data_cnt == 2'd0) begin
          data1_hold <= fifo_dout[6:0];
          if (exp_len == 2'd1) begin
            msg_q    <= '{run_status, fifo_dout[6:0], 7'd0, 2'd1};
            data_cnt <= '0;
`ifndef MIDI_RUNNING_STATUS_EN
            run_valid <= 1'b0;
`endif
          end else begin
            data_cnt <= 2'd1;
          end
        end else begin
          msg_q    <= '{run_status, data1_hold, fifo_dout[6:0], 2'd2};
          data_cnt <= '0;
`ifndef MIDI_RUNNING_STATUS_EN
          run_valid <= 1'b0;
`endif
        end
      end else if (drop_q != '1) begin
        drop_q <= drop_q + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb_midi_msg_parser: scoreboard bench for midi_msg_parser with a queue-based
// FIFO model. Follows MIDI_RUNNING_STATUS_EN when it is defined for the build.
module tb_midi_msg_parser;

  typedef struct packed {
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [1:0] len;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic       msg_valid;
  logic       msg_ready = 1'b1;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic [1:0] msg_len;
  logic [7:0] drop_cnt;

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         exp_drop = 0;
  int         cyc = 0;
  int         last_rd = 0;
  int         last_lat = -1;
  logic       prev_valid = 1'b0;
  logic       prev_rd = 1'b0;

  midi_msg_parser #(.DROP_CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_status (msg_status),
    .msg_data1  (msg_data1),
    .msg_data2  (msg_data2),
    .msg_len    (msg_len),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: a pop presents the byte on fifo_dout the following cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: pop-strobe protocol, latency capture and scoreboard compare on handshake.
  always @(negedge clk) begin
    if (reset) begin
      if (fifo_rd_en) begin
        tests++;
        if (fifo_empty || msg_valid || prev_rd) begin
          fails++;
          $display("[TB] FAIL rd_en_protocol: rd_en=1 empty=%0b valid=%0b prev_rd=%0b, required no pop",
                   fifo_empty, msg_valid, prev_rd);
        end
        last_rd = cyc;
      end
      if (msg_valid && !prev_valid) last_lat = cyc - last_rd;
      if (msg_valid && msg_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_msg: got %h/%h/%h len %0d, required none",
                   msg_status, msg_data1, msg_data2, msg_len);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({msg_status, msg_data1, msg_data2, msg_len} !== e) begin
            fails++;
            $display("[TB] FAIL msg_fields: got %h/%h/%h len %0d, required %h/%h/%h len %0d",
                     msg_status, msg_data1, msg_data2, msg_len, e.st, e.d1, e.d2, e.len);
          end
        end
      end
    end
    prev_valid = msg_valid;
    prev_rd    = fifo_rd_en;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic exp_msg(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                         input logic [1:0] len);
    exp_t e;
    e = {st, d1, d2, len};
    exp_q.push_back(e);
  endtask

  task automatic add_drops(input int n);
    exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || msg_valid) && n < budget) begin
      tick(1);
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("[TB] FAIL %s_timeout: %0d messages pending, %0d bytes queued, required 0/0",
               name, exp_q.size(), fifo_q.size());
      exp_q.delete();
    end
    tick(6);
  endtask

  task automatic check_drop(input string name);
    tests++;
    if (drop_cnt !== exp_drop[7:0]) begin
      fails++;
      $display("[TB] FAIL %s_drop_cnt: got %0d, required %0d", name, drop_cnt, exp_drop);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!msg_valid && n < 50) begin
      tick(1);
      n++;
    end
    tests++;
    if (!msg_valid) begin
      fails++;
      $display("[TB] FAIL %s_valid_timeout: msg_valid=0, required 1", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    tests++;
    if ({fifo_rd_en, msg_valid, msg_status, msg_data1, msg_data2, msg_len, drop_cnt} !== 41'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %h, required 0",
               {fifo_rd_en, msg_valid, msg_status, msg_data1, msg_data2, msg_len, drop_cnt});
    end
    tick(1);
    push_byte(8'hFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (fifo_rd_en !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_rd_en: got %b, required 0", fifo_rd_en);
      end
    end
    tick(1);
    reset = 1'b1;
    exp_msg(8'hFE, 7'h00, 7'h00, 2'd0);
    wait_drain("reset_release", 40);
    check_drop("reset");
  endtask

  task automatic test_note_on();
    last_lat = -1;
    exp_msg(8'h90, 7'h3C, 7'h64, 2'd2);
    push_byte(8'h90); push_byte(8'h3C); push_byte(8'h64);
    wait_drain("note_on", 60);
    tests++;
    if (last_lat !== 2) begin
      fails++;
      $display("[TB] FAIL note_on_latency: got %0d cycles, required 2", last_lat);
    end
    check_drop("note_on");
  endtask

  task automatic test_running_status();
    exp_msg(8'h90, 7'h3C, 7'h64, 2'd2);
`ifdef MIDI_RUNNING_STATUS_EN
    exp_msg(8'h90, 7'h40, 7'h00, 2'd2);
`else
    add_drops(2);
`endif
    push_byte(8'h90); push_byte(8'h3C); push_byte(8'h64); push_byte(8'h40); push_byte(8'h00);
    wait_drain("running_status", 80);
    check_drop("running_status");
  endtask

  task automatic test_realtime();
    exp_msg(8'hF8, 7'h00, 7'h00, 2'd0);
    exp_msg(8'h90, 7'h3C, 7'h64, 2'd2);
    push_byte(8'h90); push_byte(8'h3C); push_byte(8'hF8); push_byte(8'h64);
    wait_drain("realtime", 80);
    check_drop("realtime");
  endtask

  task automatic test_program();
    exp_msg(8'hC5, 7'h07, 7'h00, 2'd1);
    push_byte(8'hC5); push_byte(8'h07);
    wait_drain("program", 60);
    check_drop("program");
  endtask

  task automatic test_backpressure();
    msg_ready = 1'b0;
    exp_msg(8'hB2, 7'h07, 7'h7F, 2'd2);
    exp_msg(8'hC1, 7'h05, 7'h00, 2'd1);
    push_byte(8'hB2); push_byte(8'h07); push_byte(8'h7F); push_byte(8'hC1); push_byte(8'h05);
    wait_valid("backpressure");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({msg_valid, msg_status, msg_data1, msg_data2, msg_len, fifo_rd_en} !==
          {1'b1, 8'hB2, 7'h07, 7'h7F, 2'd2, 1'b0}) begin
        fails++;
        $display("[TB] FAIL backpressure_hold: valid=%b %h/%h/%h len %0d rd_en=%b, required 1 b2/07/7f len 2 rd_en=0",
                 msg_valid, msg_status, msg_data1, msg_data2, msg_len, fifo_rd_en);
      end
    end
    tick(1);
    msg_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (msg_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL backpressure_release: msg_valid=%b, required 0", msg_valid);
    end
    tick(1);
    wait_drain("backpressure", 60);
    check_drop("backpressure");
  endtask

  task automatic test_sysex_saturation();
    push_byte(8'hF0); push_byte(8'h01); push_byte(8'h02); push_byte(8'hF7); push_byte(8'h3C);
    add_drops(3);
    wait_drain("sysex", 60);
    check_drop("sysex");
    for (int i = 0; i < 300; i++) push_byte(8'(i % 128));
    add_drops(300);
    wait_drain("saturation", 1000);
    check_drop("saturation");
    msg_ready = 1'b0;
    push_byte(8'h90); push_byte(8'h3C); push_byte(8'h64);
    wait_valid("async_reset");
    #2;
    reset = 1'b0;
    exp_drop = 0;
    #1;
    tests++;
    if ({fifo_rd_en, msg_valid, msg_status, msg_data1, msg_data2, msg_len, drop_cnt} !== 41'd0) begin
      fails++;
      $display("[TB] FAIL async_reset_outputs: got %h, required 0",
               {fifo_rd_en, msg_valid, msg_status, msg_data1, msg_data2, msg_len, drop_cnt});
    end
    tick(2);
    reset = 1'b1;
    msg_ready = 1'b1;
    push_byte(8'h11);
    add_drops(1);
    exp_msg(8'hD3, 7'h22, 7'h00, 2'd1);
    push_byte(8'hD3); push_byte(8'h22);
    wait_drain("post_reset", 60);
    check_drop("post_reset");
  endtask

  // Global bound so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_program();
    test_backpressure();
    test_sysex_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
